except_ctrl: RTL and testbench
==============================

# except_ctrl

Parametrised, registered exception/interrupt controller at the memory/commit stage, feeding CP0 and the pipeline flush network. It prioritises synchronous exception flags and synchronised hardware interrupts into a MIPS excepttype/ExcCode and captures EPC, BadVAddr and BD. It then runs a report/flush handshake so that exactly one exception is delivered per flush window.

## Interface
- `N_HW_INT`, 6, hardware interrupt lines mapped to Cause.IP[2+N_HW_INT-1:2]; legal range 1..6.
- `SYNC_STAGES`, 2, flip-flop stages per interrupt line; ≥2.
- `FLUSH_CYCLES`, 2, cycles `flush_o` is held; ≥1.
- `clk` in 1 — the only clock.
- `rst_n` in 1 — asynchronous assert, active-low reset.
- `inst_valid_i` in 1 — a real (non-bubble) instruction is present at commit.
- `except_i` in 8 — [7] fetch AdEL, [6] syscall, [5] break, [4] eret, [3] RI, [2] Ov, [1:0] reserved.
- `adel_i`, `ades_i` in 1 each — data load/store address error.
- `pc_i` in 32 — commit PC.
- `bad_addr_i` in 32 — data address of the load/store.
- `in_delay_slot_i` in 1 — the commit instruction is in a branch delay slot.
- `hw_int_i` in `N_HW_INT` — asynchronous interrupt lines.
- `cp0_status_i`, `cp0_cause_i` in 32 each — live CP0 Status/Cause; IM[15:8], EXL[1], IE[0], Cause.IP[9:8] are used.
- `cp0_ready_i` in 1 — CP0 has accepted the exception write.
- `except_valid_o` out 1 — exception report valid; held until accepted.
- `excepttype_o` out 32 — 0x01 Int, 0x04 AdEL, 0x05 AdES, 0x08 Sys, 0x09 Bp, 0x0e ERET, 0x0a RI, 0x0c Ov.
- `epc_o`, `badvaddr_o` out 32; `bd_o` out 1.
- `ip_o` out 8 — merged pending bits for Cause.IP.
- `flush_o` out 1 — pipeline flush.
- `busy_o` out 1 — the FSM is not IDLE.

## Operation
- FSM states and transitions:
  - IDLE → REPORT when an exception is detected.
  - REPORT → FLUSH on `cp0_ready_i`.
  - FLUSH → IDLE when the flush counter reaches `FLUSH_CYCLES`.
- Detection, IDLE only, gated by `inst_valid_i`. Priority, highest first:
  - Int: `(ip_o[7:0] & Status.IM) != 0`, with EXL=0 and IE=1.
  - `except_i[7] | adel_i`
  - `ades_i`
  - `except_i[6]`, then `[5]`, `[4]`, `[3]`, `[2]`.
- `ip_o`:
  - [1:0] = `cp0_cause_i[9:8]` (software interrupts).
  - [2+k] = synchronised `hw_int_i[k]`; level-sensitive, not sticky.
  - Unused bits are 0.
- Capture on the IDLE→REPORT edge:
  - `epc_o` = `pc_i - 4` if `in_delay_slot_i`, else `pc_i`.
  - `bd_o` = `in_delay_slot_i`.
  - `badvaddr_o` = `pc_i` for fetch AdEL (`except_i[7]`), `bad_addr_i` for `adel_i`/`ades_i`, otherwise unchanged.
- Capture values are held stable through REPORT and FLUSH.
- In REPORT and FLUSH all new exception inputs are ignored; the flushed instructions are discarded.
- ERET (0x0e) follows the same path; CP0 decodes it.
- `flush_o` = 1 for exactly `FLUSH_CYCLES` cycles in FLUSH. The counter width is `$clog2(FLUSH_CYCLES+1)`.

## Timing
- All outputs are registered; none is combinational from inputs.
- Reset values:
  - State IDLE.
  - `except_valid_o`, `flush_o`, `busy_o`, `bd_o` = 0.
  - `excepttype_o`, `epc_o`, `badvaddr_o`, `ip_o` = 0.
  - Synchroniser flops and counter = 0.
- Latencies:
  - Detection in cycle N → `except_valid_o` = 1 in N+1.
  - `cp0_ready_i` sampled high in cycle M (while valid) → valid = 0 and `flush_o` = 1 from M+1.
  - `hw_int_i` edge → `ip_o` change after `SYNC_STAGES`+1 cycles.
- `cp0_ready_i` already high at N+1 → one-cycle REPORT. `cp0_ready_i` outside REPORT is ignored.
- `rst_n` low mid-REPORT or mid-FLUSH aborts immediately to reset values; no partial flush is completed.
- After FLUSH, IDLE accepts a new detection in the very next cycle.

## Configuration
- `EXCEPT_TIMER_INT_EN` defined:
  - Adds inputs `count_i[31:0]`, `compare_i[31:0]`, `compare_wr_i`.
  - When `count_i == compare_i`, a sticky timer-pending flop sets and drives `ip_o[7]`.
  - `compare_wr_i` clears the flop; if clear and match occur together, clear wins.
  - The flop resets to 0.
  - Legal `N_HW_INT` is then 1..5.
- `EXCEPT_TIMER_INT_EN` undefined: the timer ports and flop are absent, and `ip_o[7]` comes only from `hw_int_i[5]` when `N_HW_INT` = 6.

## Structure
- Shared `except_pkg`:
  - Excepttype constants `EXC_INT`, `EXC_ADEL`, `EXC_ADES`, `EXC_SYS`, `EXC_BP`, `EXC_ERET`, `EXC_RI`, `EXC_OV`.
  - `except_i` bit-index constants.
  - FSM state enum `exc_state_t`.
- Sub-module `int_sync`: one `SYNC_STAGES`-deep synchroniser, instantiated `N_HW_INT` times via generate.

## Test plan
- Reset with `hw_int_i` high → all outputs 0. `ip_o[2]` = 1 appears only `SYNC_STAGES`+1 cycles after `rst_n` rises.
- `except_i` = 0x44 (syscall+RI), `pc_i` = 0xBFC00100, `in_delay_slot_i` = 1, IDLE → next cycle `excepttype_o` = 0x08, `epc_o` = 0xBFC000FC, `bd_o` = 1, valid = 1.
- Valid held; `cp0_ready_i` low 3 cycles then high → valid drops the cycle after ready, `flush_o` high exactly `FLUSH_CYCLES` (2) cycles, `busy_o` low afterwards.
- `hw_int_i[0]` = 1, IM = 0x04, IE = 1, EXL = 0, with simultaneous `ades_i` → `excepttype_o` = 0x01, `badvaddr_o` unchanged. With EXL = 1 instead → 0x05, `badvaddr_o` = `bad_addr_i`.
- New `except_i[2]` during FLUSH → ignored, no second valid. `rst_n` pulsed low in REPORT → valid and flush = 0 immediately.
- With `EXCEPT_TIMER_INT_EN`: `count_i` = `compare_i` = 0x100 → `ip_o[7]` = 1 and sticky after `count_i` changes. `compare_wr_i` → cleared next cycle.

Source files
------------

// File: rtl/except_pkg.sv
// except_pkg: shared definitions for the commit-stage exception controller.
//   - EXC_* : MIPS excepttype codes presented to CP0 on excepttype_o
//   - EXI_* : bit positions inside the except_i flag vector
//   - ST_*  : CP0 Status bit positions the controller reads
//   - exc_state_t : controller FSM state encoding
package except_pkg;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;

    localparam int EXI_ADEL_IF = 7;
    localparam int EXI_SYS     = 6;
    localparam int EXI_BP      = 5;
    localparam int EXI_ERET    = 4;
    localparam int EXI_RI      = 3;
    localparam int EXI_OV      = 2;

    localparam int ST_IM_LO = 8;
    localparam int ST_EXL   = 1;
    localparam int ST_IE    = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REPORT = 2'd1,
        ST_FLUSH  = 2'd2
    } exc_state_t;

endpackage

// File: rtl/int_sync.sv
// int_sync: STAGES-deep flip-flop synchroniser for one asynchronous
// interrupt line.
//   clk, rst_n : clock, asynchronous active-low reset (flops clear to 0)
//   d          : asynchronous input
//   q          : synchronised output, STAGES cycles behind d
module int_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/except_ctrl.sv
// except_ctrl: registered exception/interrupt controller at the commit stage.
// Prioritises exception flags and synchronised interrupts into a MIPS
// excepttype, captures EPC/BadVAddr/BD, then runs a report/flush handshake so
// that exactly one exception is delivered per flush window.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   inst_valid_i             real instruction present at commit
//   except_i[7:0]            [7] fetch AdEL [6] sys [5] bp [4] eret [3] RI [2] Ov
//   adel_i, ades_i           data load/store address error
//   pc_i, bad_addr_i         commit PC, data address
//   in_delay_slot_i          commit instruction sits in a delay slot
//   hw_int_i[N_HW_INT-1:0]   asynchronous interrupt lines
//   cp0_status_i/cause_i     live CP0 Status / Cause
//   cp0_ready_i              CP0 accepted the exception report
//   except_valid_o, excepttype_o, epc_o, badvaddr_o, bd_o   exception report
//   ip_o[7:0]                merged pending bits for Cause.IP
//   flush_o, busy_o          pipeline flush, controller not idle
//   dbg_state_o[1:0]         current FSM state (exc_state_t encoding)
//
// Optional feature: define EXCEPT_TIMER_INT_EN to add count_i/compare_i/
// compare_wr_i and a sticky timer-pending flop driving ip_o[7]
// (N_HW_INT must then be 1..5).
//
// Report handshake: except_valid_o rises the cycle after detection and holds,
// with all captured fields stable, until cp0_ready_i is sampled high while
// valid; the next cycle valid drops and flush_o is held for FLUSH_CYCLES
// cycles. cp0_ready_i is ignored outside the report phase.
module except_ctrl
    import except_pkg::*;
#(
    parameter int N_HW_INT     = 6,
    parameter int SYNC_STAGES  = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inst_valid_i,
    input  logic [7:0]          except_i,
    input  logic                adel_i,
    input  logic                ades_i,
    input  logic [31:0]         pc_i,
    input  logic [31:0]         bad_addr_i,
    input  logic                in_delay_slot_i,
    input  logic [N_HW_INT-1:0] hw_int_i,
    input  logic [31:0]         cp0_status_i,
    input  logic [31:0]         cp0_cause_i,
    input  logic                cp0_ready_i,
`ifdef EXCEPT_TIMER_INT_EN
    input  logic [31:0]         count_i,
    input  logic [31:0]         compare_i,
    input  logic                compare_wr_i,
`endif
    output logic                except_valid_o,
    output logic [31:0]         excepttype_o,
    output logic [31:0]         epc_o,
    output logic [31:0]         badvaddr_o,
    output logic                bd_o,
    output logic [7:0]          ip_o,
    output logic                flush_o,
    output logic                busy_o,
    output logic [1:0]          dbg_state_o
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES);

    exc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture;

    logic [N_HW_INT-1:0] hw_sync;
    logic [7:0]          ip_d;
    logic                int_req;
    logic                hit;
    logic [31:0]         type_sel;
    logic                badv_from_pc;
    logic                badv_from_data;

    // Status/Cause fields and reserved except_i bits this block never reads.
    logic unused_bits;
    assign unused_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                           cp0_cause_i[31:10], cp0_cause_i[7:0], except_i[1:0]};

    for (genvar k = 0; k < N_HW_INT; k++) begin : g_sync
        int_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (hw_int_i[k]),
            .q     (hw_sync[k])
        );
    end

    // Pending bits: software interrupts from Cause, then one bit per line.
    always_comb begin
        ip_d      = 8'h00;
        ip_d[1:0] = cp0_cause_i[9:8];
        for (int k = 0; k < N_HW_INT; k++) begin
            ip_d[2+k] = hw_sync[k];
        end
`ifdef EXCEPT_TIMER_INT_EN
        // ip_o[7] is the sticky timer flop; a Compare write beats a match.
        if (compare_wr_i) begin
            ip_d[7] = 1'b0;
        end else if (count_i == compare_i) begin
            ip_d[7] = 1'b1;
        end else begin
            ip_d[7] = ip_o[7];
        end
`endif
    end

    assign int_req = (|(ip_o & cp0_status_i[ST_IM_LO+7:ST_IM_LO]))
                   & ~cp0_status_i[ST_EXL] & cp0_status_i[ST_IE];

    // Priority encoder, highest first.
    always_comb begin
        hit            = 1'b1;
        type_sel       = 32'h0;
        badv_from_pc   = 1'b0;
        badv_from_data = 1'b0;
        if (int_req) begin
            type_sel = EXC_INT;
        end else if (except_i[EXI_ADEL_IF]) begin
            type_sel     = EXC_ADEL;
            badv_from_pc = 1'b1;
        end else if (adel_i) begin
            type_sel       = EXC_ADEL;
            badv_from_data = 1'b1;
        end else if (ades_i) begin
            type_sel       = EXC_ADES;
            badv_from_data = 1'b1;
        end else if (except_i[EXI_SYS]) begin
            type_sel = EXC_SYS;
        end else if (except_i[EXI_BP]) begin
            type_sel = EXC_BP;
        end else if (except_i[EXI_ERET]) begin
            type_sel = EXC_ERET;
        end else if (except_i[EXI_RI]) begin
            type_sel = EXC_RI;
        end else if (except_i[EXI_OV]) begin
            type_sel = EXC_OV;
        end else begin
            hit = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inst_valid_i && hit) begin
                    state_d = ST_REPORT;
                    capture = 1'b1;
                end
            end
            ST_REPORT: begin
                if (cp0_ready_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                // cnt counts flush cycles already completed.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == FLUSH_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Status outputs are registered copies of the next state so they line up
    // with state_q without any combinational path from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            except_valid_o <= 1'b0;
            flush_o        <= 1'b0;
            busy_o         <= 1'b0;
            ip_o           <= 8'h00;
            excepttype_o   <= 32'h0;
            epc_o          <= 32'h0;
            badvaddr_o     <= 32'h0;
            bd_o           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            except_valid_o <= (state_d == ST_REPORT);
            flush_o        <= (state_d == ST_FLUSH);
            busy_o         <= (state_d != ST_IDLE);
            ip_o           <= ip_d;
            if (capture) begin
                excepttype_o <= type_sel;
                epc_o        <= in_delay_slot_i ? (pc_i - 32'd4) : pc_i;
                bd_o         <= in_delay_slot_i;
                if (badv_from_pc) begin
                    badvaddr_o <= pc_i;
                end else if (badv_from_data) begin
                    badvaddr_o <= bad_addr_i;
                end
            end
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_except_ctrl.sv
module tb_except_ctrl;

`ifdef EXCEPT_TIMER_INT_EN
    localparam int N_HW_INT = 5;
`else
    localparam int N_HW_INT = 6;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                inst_valid;
    logic [7:0]          exc;
    logic                adel;
    logic                ades;
    logic [31:0]         pc;
    logic [31:0]         bad_addr;
    logic                ds;
    logic [N_HW_INT-1:0] hw_int;
    logic [31:0]         status;
    logic [31:0]         cause;
    logic                ready;
`ifdef EXCEPT_TIMER_INT_EN
    logic [31:0]         count;
    logic [31:0]         compare;
    logic                compare_wr;
`endif
    logic                valid_o;
    logic [31:0]         type_o;
    logic [31:0]         epc_o;
    logic [31:0]         badv_o;
    logic                bd_o;
    logic [7:0]          ip_o;
    logic                flush_o;
    logic                busy_o;
    logic [1:0]          state_o;

    int n_checks = 0;
    int n_errors = 0;

    except_ctrl #(.N_HW_INT(N_HW_INT), .SYNC_STAGES(2), .FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inst_valid_i    (inst_valid),
        .except_i        (exc),
        .adel_i          (adel),
        .ades_i          (ades),
        .pc_i            (pc),
        .bad_addr_i      (bad_addr),
        .in_delay_slot_i (ds),
        .hw_int_i        (hw_int),
        .cp0_status_i    (status),
        .cp0_cause_i     (cause),
        .cp0_ready_i     (ready),
`ifdef EXCEPT_TIMER_INT_EN
        .count_i         (count),
        .compare_i       (compare),
        .compare_wr_i    (compare_wr),
`endif
        .except_valid_o  (valid_o),
        .excepttype_o    (type_o),
        .epc_o           (epc_o),
        .badvaddr_o      (badv_o),
        .bd_o            (bd_o),
        .ip_o            (ip_o),
        .flush_o         (flush_o),
        .busy_o          (busy_o),
        .dbg_state_o     (state_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [7:0]  exc;
        logic        adel;
        logic        ades;
        logic        ds;
        logic [31:0] pc;
        logic [31:0] bad;
        logic        hit;
        logic [31:0] e_type;
        logic [31:0] e_epc;
        logic [31:0] e_badv;
        logic        e_bd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_valid = 1'b0;
        exc        = 8'h00;
        adel       = 1'b0;
        ades       = 1'b0;
        ds         = 1'b0;
    endtask

    // Accept the report immediately and walk through the two flush cycles.
    task automatic handshake(input string tag);
        clear_inputs();
        ready = 1'b1;
        step();
        check({tag, " valid after ready"}, {31'b0, valid_o}, 32'd0);
        check({tag, " flush 1"}, {31'b0, flush_o}, 32'd1);
        ready = 1'b0;
        step();
        check({tag, " flush 2"}, {31'b0, flush_o}, 32'd1);
        step();
        check({tag, " flush end"}, {31'b0, flush_o}, 32'd0);
        check({tag, " busy end"}, {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 32'hBFC0_0100, 32'h0000_1234, 1'b1, 32'h08, 32'hBFC0_00FC, 32'h0000_0000, 1'b1};
        vecs[1] = '{1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 32'h8000_1000, 32'hDEAD_0000, 1'b1, 32'h04, 32'h8000_1000, 32'h8000_1000, 1'b0};
        vecs[2] = '{1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 32'h8000_2000, 32'h0040_0003, 1'b1, 32'h04, 32'h8000_2000, 32'h0040_0003, 1'b0};
        vecs[3] = '{1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 32'h8000_3000, 32'h1000_0002, 1'b1, 32'h05, 32'h8000_3000, 32'h1000_0002, 1'b0};
        vecs[4] = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 32'h8000_4004, 32'h0000_FFFF, 1'b1, 32'h09, 32'h8000_4000, 32'h1000_0002, 1'b1};
        vecs[5] = '{1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 32'h8000_5000, 32'h0000_0000, 1'b1, 32'h0E, 32'h8000_5000, 32'h1000_0002, 1'b0};
        vecs[6] = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 32'h8000_5100, 32'h0000_0000, 1'b1, 32'h0A, 32'h8000_5100, 32'h1000_0002, 1'b0};
        vecs[7] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 32'h8000_5200, 32'h0000_0000, 1'b1, 32'h0C, 32'h8000_5200, 32'h1000_0002, 1'b0};
        vecs[8] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 32'h8000_5300, 32'h0000_0000, 1'b0, 32'h00, 32'h0,         32'h0,         1'b0};
        vecs[9] = '{1'b0, 8'h40, 1'b0, 1'b1, 1'b0, 32'h8000_5400, 32'h0000_0000, 1'b0, 32'h00, 32'h0,         32'h0,         1'b0};

        rst_n    = 1'b0;
        clear_inputs();
        pc       = 32'h0;
        bad_addr = 32'h0;
        hw_int   = '0;
        hw_int[0] = 1'b1;
        status   = 32'h0;
        cause    = 32'h0;
        ready    = 1'b0;
`ifdef EXCEPT_TIMER_INT_EN
        count      = 32'h0;
        compare    = 32'hFFFF_FFFF;
        compare_wr = 1'b0;
`endif

        // Reset with an interrupt line high: everything stays zero.
        repeat (3) step();
        check("rst valid", {31'b0, valid_o}, 32'd0);
        check("rst flush", {31'b0, flush_o}, 32'd0);
        check("rst busy", {31'b0, busy_o}, 32'd0);
        check("rst bd", {31'b0, bd_o}, 32'd0);
        check("rst type", type_o, 32'h0);
        check("rst epc", epc_o, 32'h0);
        check("rst badv", badv_o, 32'h0);
        check("rst ip", {24'b0, ip_o}, 32'h0);
        check("rst state", {30'b0, state_o}, 32'd0);

        // Synchroniser latency: ip_o[2] shows up 3 cycles after release.
        rst_n = 1'b1;
        step();
        check("ip lat 1", {24'b0, ip_o}, 32'h00);
        step();
        check("ip lat 2", {24'b0, ip_o}, 32'h00);
        step();
        check("ip lat 3", {24'b0, ip_o}, 32'h04);
        cause = 32'h0000_0300;
        step();
        check("ip sw bits", {24'b0, ip_o}, 32'h07);
        cause = 32'h0;
        step();
        check("ip sw clear", {24'b0, ip_o}, 32'h04);

        // Table: single exceptions with interrupts disabled (IE=0).
        for (int i = 0; i < 10; i++) begin
            inst_valid = vecs[i].iv;
            exc        = vecs[i].exc;
            adel       = vecs[i].adel;
            ades       = vecs[i].ades;
            ds         = vecs[i].ds;
            pc         = vecs[i].pc;
            bad_addr   = vecs[i].bad;
            step();
            if (vecs[i].hit) begin
                check($sformatf("v%0d valid", i), {31'b0, valid_o}, 32'd1);
                check($sformatf("v%0d type", i), type_o, vecs[i].e_type);
                check($sformatf("v%0d epc", i), epc_o, vecs[i].e_epc);
                check($sformatf("v%0d badv", i), badv_o, vecs[i].e_badv);
                check($sformatf("v%0d bd", i), {31'b0, bd_o}, {31'b0, vecs[i].e_bd});
                handshake($sformatf("v%0d", i));
            end else begin
                check($sformatf("v%0d no valid", i), {31'b0, valid_o}, 32'd0);
                check($sformatf("v%0d no busy", i), {31'b0, busy_o}, 32'd0);
                clear_inputs();
            end
        end

        // Interrupt outranks AdES; badvaddr untouched; ready delayed 3 cycles.
        status   = 32'h0000_0401;
        inst_valid = 1'b1;
        ades     = 1'b1;
        bad_addr = 32'hCAFE_0000;
        pc       = 32'h8000_6000;
        step();
        check("int valid", {31'b0, valid_o}, 32'd1);
        check("int type", type_o, 32'h01);
        check("int badv kept", badv_o, 32'h1000_0002);
        clear_inputs();
        pc = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("int hold valid %0d", c), {31'b0, valid_o}, 32'd1);
            check($sformatf("int hold epc %0d", c), epc_o, 32'h8000_6000);
        end
        handshake("int");

        // Same request with EXL=1: interrupt masked, AdES taken.
        status   = 32'h0000_0403;
        inst_valid = 1'b1;
        ades     = 1'b1;
        pc       = 32'h8000_7000;
        step();
        check("exl type", type_o, 32'h05);
        check("exl badv", badv_o, 32'hCAFE_0000);
        handshake("exl");
        status = 32'h0;

        // New Ov flag during FLUSH is ignored.
        inst_valid = 1'b1;
        exc        = 8'h40;
        pc         = 32'h8000_8000;
        step();
        check("fl type", type_o, 32'h08);
        clear_inputs();
        ready = 1'b1;
        step();
        check("fl flush1", {31'b0, flush_o}, 32'd1);
        ready      = 1'b0;
        inst_valid = 1'b1;
        exc        = 8'h04;
        step();
        check("fl flush2", {31'b0, flush_o}, 32'd1);
        check("fl no valid", {31'b0, valid_o}, 32'd0);
        clear_inputs();
        step();
        check("fl idle valid", {31'b0, valid_o}, 32'd0);
        check("fl idle busy", {31'b0, busy_o}, 32'd0);
        step();
        check("fl still idle", {31'b0, valid_o}, 32'd0);

        // Ready already high: one-cycle REPORT, then detection in first IDLE cycle.
        ready      = 1'b1;
        inst_valid = 1'b1;
        exc        = 8'h08;
        pc         = 32'h8000_9000;
        step();
        check("fast valid", {31'b0, valid_o}, 32'd1);
        check("fast type", type_o, 32'h0A);
        clear_inputs();
        step();
        check("fast valid drop", {31'b0, valid_o}, 32'd0);
        check("fast flush1", {31'b0, flush_o}, 32'd1);
        ready = 1'b0;
        step();
        check("fast flush2", {31'b0, flush_o}, 32'd1);
        inst_valid = 1'b1;
        exc        = 8'h04;
        pc         = 32'h8000_A000;
        step();
        check("b2b idle", {31'b0, busy_o}, 32'd0);
        step();
        check("b2b valid", {31'b0, valid_o}, 32'd1);
        check("b2b type", type_o, 32'h0C);
        check("b2b epc", epc_o, 32'h8000_A000);
        handshake("b2b");

        // Reset pulse during REPORT aborts at once.
        inst_valid = 1'b1;
        exc        = 8'h20;
        step();
        check("rr valid", {31'b0, valid_o}, 32'd1);
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("rr valid 0", {31'b0, valid_o}, 32'd0);
        check("rr flush 0", {31'b0, flush_o}, 32'd0);
        check("rr busy 0", {31'b0, busy_o}, 32'd0);
        check("rr type 0", type_o, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("rr after", {31'b0, busy_o}, 32'd0);

        // Reset pulse during FLUSH: no remaining flush cycle.
        inst_valid = 1'b1;
        exc        = 8'h20;
        step();
        clear_inputs();
        ready = 1'b1;
        step();
        check("rf flush", {31'b0, flush_o}, 32'd1);
        ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rf flush 0", {31'b0, flush_o}, 32'd0);
        check("rf busy 0", {31'b0, busy_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("rf after", {31'b0, flush_o}, 32'd0);

`ifdef EXCEPT_TIMER_INT_EN
        // Sticky timer pending bit, cleared by a Compare write.
        count   = 32'h100;
        compare = 32'h100;
        step();
        check("tmr set", {31'b0, ip_o[7]}, 32'd1);
        count = 32'h101;
        step();
        check("tmr sticky", {31'b0, ip_o[7]}, 32'd1);
        compare_wr = 1'b1;
        step();
        check("tmr clear", {31'b0, ip_o[7]}, 32'd0);
        compare_wr = 1'b0;
        step();
        check("tmr stays clear", {31'b0, ip_o[7]}, 32'd0);
`else
        // Without the timer, ip_o[7] follows hw_int[5].
        hw_int[5] = 1'b1;
        step();
        step();
        check("ip7 early", {31'b0, ip_o[7]}, 32'd0);
        step();
        check("ip7 set", {31'b0, ip_o[7]}, 32'd1);
        hw_int[5] = 1'b0;
        repeat (3) step();
        check("ip7 clear", {31'b0, ip_o[7]}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
